// File: rtl/signal_phase_ctrl_pkg.sv
// signal_pkg: shared types and helpers for the traffic-signal phase controller.
//   light_e   : 2-bit lamp code per approach (RED=00, YELLOW=01, GREEN=10)
//   phase_e   : controller phase (all-red clearance, green, yellow)
//   lamp_pack : lamp code of approach `idx` given the phase and the active approach
package signal_pkg;

   typedef enum logic [1:0] {
      RED    = 2'b00,
      YELLOW = 2'b01,
      GREEN  = 2'b10
   } light_e;

   typedef enum logic [1:0] {
      PH_ALL_RED = 2'd0,
      PH_GREEN   = 2'd1,
      PH_YELLOW  = 2'd2
   } phase_e;

   // Only the active approach may show a non-RED lamp; everything else is RED.
   // The caller packs the per-approach results into the lights vector.
   function automatic light_e lamp_pack(phase_e ph, int unsigned dir, int unsigned idx);
      light_e l;
      l = RED;
      if (dir == idx) begin
         case (ph)
            PH_GREEN:  l = GREEN;
            PH_YELLOW: l = YELLOW;
            default:   l = RED;
         endcase
      end
      return l;
   endfunction

endpackage

// File: rtl/signal_phase_ctrl_if.sv
// signal_phase_ctrl_if: bundle between the phase controller and its users.
//   busy        : per-approach high-traffic flag (from image processing)
//   emg_req     : level emergency all-red request
//   lights      : packed lamp codes, approach i at [2i+1:2i]
//   active_dir  : approach owning (or last owning) green
//   left_time   : seconds remaining in the current phase
//   long_green  : current/last green used the long duration
//   phase_valid : one-cycle pulse on the first cycle of a new phase
//   emg_active  : all-red being held for an emergency
//   tick_sec    : one-cycle pulse per second
// master = the surrounding system, slave = the controller.
interface signal_phase_ctrl_if #(
   parameter int N_DIR  = 2,
   parameter int TIME_W = 5
);
   localparam int DIR_W = (N_DIR > 1) ? $clog2(N_DIR) : 1;

   logic [N_DIR-1:0]   busy;
   logic               emg_req;
   logic [2*N_DIR-1:0] lights;
   logic [DIR_W-1:0]   active_dir;
   logic [TIME_W-1:0]  left_time;
   logic               long_green;
   logic               phase_valid;
   logic               emg_active;
   logic               tick_sec;

   modport master (
      output busy, emg_req,
      input  lights, active_dir, left_time, long_green, phase_valid, emg_active, tick_sec
   );

   modport slave (
      input  busy, emg_req,
      output lights, active_dir, left_time, long_green, phase_valid, emg_active, tick_sec
   );
endinterface

// File: rtl/signal_phase_ctrl_tick_gen.sv
// tick_gen: free-running divider producing a registered one-cycle pulse every
// TICK_DIV clock cycles. The first pulse is visible TICK_DIV cycles after
// reset release.
//   clk    : system clock
//   reset  : asynchronous, active-high reset (count cleared, no pulse)
//   tick_o : one-cycle pulse per period
module tick_gen #(
   parameter int TICK_DIV = 100_000_000
) (
   input  logic clk,
   input  logic reset,
   output logic tick_o
);
   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST    = CNT_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick_q, tick_d;

   always_comb begin
      cnt_d  = cnt_q + CNT_ONE;
      tick_d = 1'b0;
      if (cnt_q == LAST) begin
         cnt_d  = '0;
         tick_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick_o = tick_q;
endmodule

// File: rtl/signal_phase_ctrl.sv
// signal_phase_ctrl: N-approach round-robin traffic-signal controller.
// Phase sequence ALL_RED -> GREEN -> YELLOW -> ALL_RED, each counted down in
// seconds from the 1 Hz tick. Green length is chosen per approach from its busy
// flag at green entry. An emergency request cuts green short into yellow and
// holds all-red until it drops.
//   clk, reset : system clock, asynchronous active-high reset
//   bus        : slave side of signal_phase_ctrl_if (busy/emg_req in,
//                lights/active_dir/left_time/long_green/phase_valid/
//                emg_active/tick_sec out)
// N_DIR >= 2, TICK_DIV >= 2, all durations >= 1; durations are truncated to
// TIME_W bits.
module signal_phase_ctrl #(
   parameter int N_DIR         = 2,
   parameter int TICK_DIV      = 100_000_000,
   parameter int TIME_W        = 5,
   parameter int T_GREEN_LONG  = 31,
   parameter int T_GREEN_SHORT = 22,
   parameter int T_YELLOW      = 3,
   parameter int T_ALL_RED     = 1
) (
   input  logic              clk,
   input  logic              reset,
   signal_phase_ctrl_if.slave bus
);
   import signal_pkg::*;

   localparam int DIR_W = (N_DIR > 1) ? $clog2(N_DIR) : 1;
   localparam logic [DIR_W-1:0]  LAST_DIR = DIR_W'(N_DIR - 1);
   localparam logic [DIR_W-1:0]  DIR_ONE  = DIR_W'(1);
   localparam logic [TIME_W-1:0] T_GL     = TIME_W'(T_GREEN_LONG);
   localparam logic [TIME_W-1:0] T_GS     = TIME_W'(T_GREEN_SHORT);
   localparam logic [TIME_W-1:0] T_Y      = TIME_W'(T_YELLOW);
   localparam logic [TIME_W-1:0] T_AR     = TIME_W'(T_ALL_RED);
   localparam logic [TIME_W-1:0] ONE      = TIME_W'(1);

   logic               tick;
   phase_e             phase_q, phase_d;
   logic [DIR_W-1:0]   dir_q, dir_d, dir_nxt;
   logic [TIME_W-1:0]  left_q, left_d;
   logic               long_q, long_d;
   logic [2*N_DIR-1:0] lights_q, lights_d;
   logic               pv_q;
   logic               emg_q, emg_d;
   logic               expire;

   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk    (clk),
      .reset  (reset),
      .tick_o (tick)
   );

   assign dir_nxt = (dir_q == LAST_DIR) ? '0 : dir_q + DIR_ONE;
   // `<=` rather than `==` so a duration truncated to 0 still leaves the phase
   // instead of wrapping the countdown.
   assign expire  = tick && (left_q <= ONE);

   always_comb begin
      phase_d = phase_q;
      dir_d   = dir_q;
      left_d  = left_q;
      long_d  = long_q;
      case (phase_q)
         PH_GREEN: begin
            // Emergency and natural expiry land in the same place.
            if (bus.emg_req || expire) begin
               phase_d = PH_YELLOW;
               left_d  = T_Y;
            end else if (tick) begin
               left_d = left_q - ONE;
            end
         end
         PH_YELLOW: begin
            // emg_req deliberately ignored: yellow always completes.
            if (expire) begin
               phase_d = PH_ALL_RED;
               left_d  = T_AR;
            end else if (tick) begin
               left_d = left_q - ONE;
            end
         end
         PH_ALL_RED: begin
            if (bus.emg_req) begin
               // Park at 1 so the first tick after release exits.
               left_d = ONE;
            end else if (expire) begin
               phase_d = PH_GREEN;
               dir_d   = dir_nxt;
               long_d  = bus.busy[dir_nxt];
               left_d  = bus.busy[dir_nxt] ? T_GL : T_GS;
            end else if (tick) begin
               left_d = left_q - ONE;
            end
         end
         default: begin
            phase_d = PH_ALL_RED;
            left_d  = T_AR;
         end
      endcase
   end

   assign emg_d = (phase_d == PH_ALL_RED) && bus.emg_req;

   // Lamps are registered from next-state so they change together with phase.
   always_comb begin
      lights_d = '0;
      for (int i = 0; i < N_DIR; i++) begin
         lights_d[2*i +: 2] = lamp_pack(phase_d, 32'(dir_d), i);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase_q  <= PH_ALL_RED;
         dir_q    <= LAST_DIR;
         left_q   <= T_AR;
         long_q   <= 1'b0;
         lights_q <= '0;
         pv_q     <= 1'b0;
         emg_q    <= 1'b0;
      end else begin
         phase_q  <= phase_d;
         dir_q    <= dir_d;
         left_q   <= left_d;
         long_q   <= long_d;
         lights_q <= lights_d;
         pv_q     <= (phase_d != phase_q);
         emg_q    <= emg_d;
      end
   end

   assign bus.lights      = lights_q;
   assign bus.active_dir  = dir_q;
   assign bus.left_time   = left_q;
   assign bus.long_green  = long_q;
   assign bus.phase_valid = pv_q;
   assign bus.emg_active  = emg_q;
   assign bus.tick_sec    = tick;
endmodule
